// File: rtl/stdin_mmio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stdin_mmio_pkg
//  Description : Shared types, address map and helpers for the stdin MMIO
//                device (load-size enum, size-to-bytes, base address).
//  Revision    : 1.0 - initial release
// ============================================================================
package stdin_mmio_pkg;

    // CPU load width encoding on the data-memory bus
    typedef enum logic [1:0] {
        LOAD_BYTE  = 2'd0,
        LOAD_HALF  = 2'd1,
        LOAD_WORD  = 2'd2,
        LOAD_DWORD = 2'd3
    } mem_load_size_t;

    // Device window: DATA at +0..+7, STATUS at +8..+15
    localparam logic [63:0] STDIN_BASE_ADDR     = 64'h0000_0000_1000_1000;
    localparam logic [63:0] STDIN_STATUS_OFFSET = 64'd8;

    // Number of bytes a load of the given size asks for
    function automatic logic [3:0] load_size_bytes(input mem_load_size_t size);
        case (size)
            LOAD_BYTE:  return 4'd1;
            LOAD_HALF:  return 4'd2;
            LOAD_WORD:  return 4'd4;
            default:    return 4'd8;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/stdin_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : stdin_fifo
//  Description : Byte FIFO with single-byte push, 8-byte peek window at the
//                head and 0..8-byte pop. Pointers wrap modulo DEPTH.
//  Revision    : 1.0 - initial release
// ============================================================================
module stdin_fifo #(
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [7:0]       push_data,
    input  logic [3:0]       pop_n,
    output logic [63:0]      peek_data,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [7:0]       r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    // Storage write; contents are don't-care after reset since pointers clear
    always_ff @(posedge clock) begin
        if (push) begin
            r_mem[r_tail] <= push_data;
        end
    end

    // Pointer and occupancy update; push and pop may happen together
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PTR_W'(pop_n);
            r_tail  <= r_tail + PTR_W'(push);
            r_count <= r_count + CNT_W'(push) - CNT_W'(pop_n);
        end
    end

    // Peek window: byte i is the entry at head+i, wrapping around the end
    for (genvar i = 0; i < 8; i++) begin : g_peek
        logic [PTR_W-1:0] w_idx;
        assign w_idx                 = r_head + PTR_W'(i);
        assign peek_data[8*i +: 8]   = r_mem[w_idx];
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/stdin_mmio.sv
`default_nettype none
// ============================================================================
//  Module      : stdin_mmio
//  Description : Simulation-side memory-mapped stdin. Host pushes bytes into
//                a FIFO; CPU loads from DATA pop up to 8 bytes little-endian
//                with null fill, loads from STATUS return occupancy/EOF.
//                Optional macro STDIN_EOF_EN enables the sticky EOF flag and
//                the all-ones EOF marker on empty DATA reads.
//  Revision    : 1.0 - initial release
// ============================================================================
module stdin_mmio
    import stdin_mmio_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [63:0]      addr,
    input  mem_load_size_t   load_size,
    output logic [63:0]      r_data,
    output logic             stdin_taken,
    input  logic             host_valid,
    input  logic [7:0]       host_data,
    output logic             host_ready,
    input  logic             host_eof,
    output logic [CNT_W-1:0] count
);

    logic [63:0] w_offset;
    logic        w_in_data;
    logic        w_in_status;
    logic [3:0]  w_n_req;
    logic [3:0]  w_n;
    logic [3:0]  w_pop_n;
    logic        w_push;
    logic [63:0] w_peek;
    logic        w_eof_flag;

    // Address decode relative to the device base; wrap-around of the
    // subtraction pushes out-of-window addresses far above the window
    assign w_offset    = addr - STDIN_BASE_ADDR;
    assign w_in_data   = (w_offset < STDIN_STATUS_OFFSET);
    assign w_in_status = !w_in_data && (w_offset < (STDIN_STATUS_OFFSET + 64'd8));

    // Bytes actually delivered: the request clipped to what the FIFO holds
    assign w_n_req = load_size_bytes(load_size);
    assign w_n     = (CNT_W'(w_n_req) > count) ? 4'(count) : w_n_req;
    assign w_pop_n = (enable && w_in_data) ? w_n : 4'd0;

    // Space check uses the registered count only, so a pop never frees a
    // slot for a push in the same cycle
    assign host_ready = (count != CNT_W'(DEPTH));
    assign w_push     = host_valid && host_ready;

    stdin_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (w_push),
        .push_data (host_data),
        .pop_n     (w_pop_n),
        .peek_data (w_peek),
        .count     (count)
    );

`ifdef STDIN_EOF_EN
    logic r_eof_flag;

    // Sticky end-of-input flag; only reset clears it
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_eof_flag <= 1'b0;
        end else if (host_eof) begin
            r_eof_flag <= 1'b1;
        end
    end

    assign w_eof_flag = r_eof_flag;
`else
    // EOF tracking disabled: flag is constant zero, host_eof has no effect
    assign w_eof_flag = host_eof & 1'b0;
`endif

    // Zero-latency read data: DATA returns head bytes with null fill,
    // STATUS returns occupancy with EOF in the top bit
    always_comb begin
        r_data = '0;
        if (enable && w_in_data) begin
            if ((count == '0) && w_eof_flag) begin
                r_data = '1;
            end else begin
                for (int i = 0; i < 8; i++) begin
                    if (4'(i) < w_n) begin
                        r_data[8*i +: 8] = w_peek[8*i +: 8];
                    end
                end
            end
        end else if (enable && w_in_status) begin
            r_data     = 64'(count);
            r_data[63] = w_eof_flag;
        end
    end

    // One-cycle-late acknowledge of any in-window load
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stdin_taken <= 1'b0;
        end else begin
            stdin_taken <= enable && (w_in_data || w_in_status);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stdin_mmio.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stdin_mmio
//  Description : Directed self-checking bench for stdin_mmio (DEPTH=16).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stdin_mmio;
    import stdin_mmio_pkg::*;

    localparam int DEPTH = 16;
    localparam int CNT_W = 5;
    localparam logic [63:0] DATA_A = STDIN_BASE_ADDR;
    localparam logic [63:0] STAT_A = STDIN_BASE_ADDR + 64'd8;

    logic             clock = 1'b0;
    logic             reset;
    logic             enable;
    logic [63:0]      addr;
    mem_load_size_t   load_size;
    logic [63:0]      r_data;
    logic             stdin_taken;
    logic             host_valid;
    logic [7:0]       host_data;
    logic             host_ready;
    logic             host_eof;
    logic [CNT_W-1:0] count;

    int vectors     = 0;
    int miscompares = 0;

    stdin_mmio #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .addr        (addr),
        .load_size   (load_size),
        .r_data      (r_data),
        .stdin_taken (stdin_taken),
        .host_valid  (host_valid),
        .host_data   (host_data),
        .host_ready  (host_ready),
        .host_eof    (host_eof),
        .count       (count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        host_valid = 1'b1;
        host_data  = b;
        tick();
        host_valid = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [63:0] a, input mem_load_size_t sz,
                      input logic [63:0] exp);
        enable    = 1'b1;
        addr      = a;
        load_size = sz;
        #1;
        chk(tag, r_data, exp);
        tick();
        enable = 1'b0;
        addr   = '0;
    endtask

    initial begin
        reset      = 1'b1;
        enable     = 1'b0;
        addr       = '0;
        load_size  = LOAD_BYTE;
        host_valid = 1'b0;
        host_data  = '0;
        host_eof   = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_ready", 64'(host_ready), 64'd1);
        chk("rst_taken", 64'(stdin_taken), 64'd0);
        chk("rst_rdata", r_data, 64'd0);

        // "Hi" then a word read: partial, null-filled
        push(8'h48);
        push(8'h69);
        chk("hi_count", 64'(count), 64'd2);
        rd("hi_word", DATA_A, LOAD_WORD, 64'h0000_0000_0000_6948);
        chk("hi_count0", 64'(count), 64'd0);
        chk("hi_taken", 64'(stdin_taken), 64'd1);
        tick();
        chk("taken_drop", 64'(stdin_taken), 64'd0);

        // Empty reads
        rd("empty_byte", DATA_A, LOAD_BYTE, 64'd0);
        chk("empty_count", 64'(count), 64'd0);
        rd("empty_status", STAT_A, LOAD_DWORD, 64'd0);

        // Fill to capacity, then an extra push must be ignored
        for (int i = 0; i < 16; i++) push(8'(i));
        chk("full_ready", 64'(host_ready), 64'd0);
        chk("full_count", 64'(count), 64'd16);
        push(8'hEE);
        chk("full_ovf_count", 64'(count), 64'd16);
        rd("full_status", STAT_A, LOAD_DWORD, 64'd16);
        chk("status_nodestr", 64'(count), 64'd16);
        rd("full_dword0", DATA_A, LOAD_DWORD, 64'h0706_0504_0302_0100);
        chk("half_count", 64'(count), 64'd8);
        chk("half_ready", 64'(host_ready), 64'd1);
        rd("full_dword1", DATA_A, LOAD_DWORD, 64'h0F0E_0D0C_0B0A_0908);
        chk("drain_count", 64'(count), 64'd0);

        // Wrap: final dword read straddles the end of storage
        for (int i = 0; i < 12; i++) push(8'(8'h80 + i));
        rd("wrap_dword0", DATA_A, LOAD_DWORD, 64'h8786_8584_8382_8180);
        for (int i = 0; i < 8; i++) push(8'(8'h8C + i));
        chk("wrap_count12", 64'(count), 64'd12);
        rd("wrap_word", DATA_A, LOAD_WORD, 64'h0000_0000_8B8A_8988);
        rd("wrap_straddle", DATA_A, LOAD_DWORD, 64'h9392_9190_8F8E_8D8C);
        chk("wrap_count0", 64'(count), 64'd0);

        // Same-cycle push and pop
        push(8'h30);
        host_valid = 1'b1;
        host_data  = 8'h41;
        rd("same_cycle", DATA_A, LOAD_BYTE, 64'h30);
        host_valid = 1'b0;
        chk("same_count", 64'(count), 64'd1);
        rd("same_next", DATA_A, LOAD_BYTE, 64'h41);

        // Out-of-window loads: zero data, no pop, no taken pulse
        push(8'h55);
        rd("oor_above", STDIN_BASE_ADDR + 64'd16, LOAD_DWORD, 64'd0);
        chk("oor_taken", 64'(stdin_taken), 64'd0);
        rd("oor_below", STDIN_BASE_ADDR - 64'd1, LOAD_DWORD, 64'd0);
        chk("oor_count", 64'(count), 64'd1);
        rd("status_one", STAT_A + 64'd7, LOAD_BYTE, 64'd1);
        chk("status_taken", 64'(stdin_taken), 64'd1);

        // Half then partial dword
        push(8'hA1);
        push(8'hA2);
        rd("half_read", DATA_A + 64'd3, LOAD_HALF, 64'hA155);
        rd("partial_dword", DATA_A, LOAD_DWORD, 64'h0000_0000_0000_00A2);
        push(8'hA3);
        rd("last_dword", DATA_A, LOAD_DWORD, 64'hA3);
        chk("final_count", 64'(count), 64'd0);

        // End-of-input handling
        push(8'h7A);
        host_eof = 1'b1;
        tick();
        host_eof = 1'b0;
        rd("eof_byte", DATA_A, LOAD_BYTE, 64'h7A);
`ifdef STDIN_EOF_EN
        rd("eof_marker", DATA_A, LOAD_BYTE, 64'hFFFF_FFFF_FFFF_FFFF);
        rd("eof_status", STAT_A, LOAD_DWORD, 64'h8000_0000_0000_0000);
`else
        rd("noeof_empty", DATA_A, LOAD_BYTE, 64'd0);
        rd("noeof_status", STAT_A, LOAD_DWORD, 64'd0);
`endif

        // Asynchronous reset mid-stream with a pending host byte
        push(8'h11);
        push(8'h22);
        host_valid = 1'b1;
        host_data  = 8'h99;
        #2;
        reset = 1'b1;
        #1;
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_ready", 64'(host_ready), 64'd1);
        enable    = 1'b1;
        addr      = STAT_A;
        load_size = LOAD_DWORD;
        #1;
        chk("arst_status", r_data, 64'd0);
        enable = 1'b0;
        tick();
        reset      = 1'b0;
        host_valid = 1'b0;
        #1;
        chk("arst_nocapture", 64'(count), 64'd0);
        push(8'h5A);
        rd("post_rst_byte", DATA_A, LOAD_DWORD, 64'h5A);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
